// File: rtl/align_dwsn_sched_pkg.sv
// Shared types and constants for the align_dwsn access scheduler.
package align_dwsn_sched_pkg;

  localparam int unsigned SRC_W = 2;

  localparam logic [SRC_W-1:0] SRC_C0  = 2'd0;
  localparam logic [SRC_W-1:0] SRC_C1  = 2'd1;
  localparam logic [SRC_W-1:0] SRC_SCR = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } scrub_state_e;

  typedef struct packed {
    logic             vld;
    logic [SRC_W-1:0] src;
  } ret_entry_t;

  // Memory return latency; never below one cycle.
  function automatic int unsigned calc_rdly(input int unsigned sram_delay,
                                            input int unsigned flopmem);
    return (sram_delay + flopmem < 1) ? 1 : sram_delay + flopmem;
  endfunction

endpackage

// File: rtl/align_dwsn_retpipe.sv
// Read-return tracker: shifts {vld,src} alongside the memory read latency.
module align_dwsn_retpipe
  import align_dwsn_sched_pkg::*;
#(
  parameter int unsigned RDLY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SRC_W-1:0] load_src,
  output logic             tail_vld,
  output logic [SRC_W-1:0] tail_src,
  output logic             scr_pend_c
);

  ret_entry_t stage [RDLY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < RDLY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= '{vld: load, src: load_src};
      for (int unsigned i = 1; i < RDLY; i++) stage[i] <= stage[i-1];
    end
  end

  assign tail_vld = stage[RDLY-1].vld;
  assign tail_src = stage[RDLY-1].src;

  // Scrub reads still travelling; the entry at the tail is returning now.
  always_comb begin
    scr_pend_c = 1'b0;
    for (int unsigned i = 0; i + 1 < RDLY; i++) begin
      if (stage[i].vld && stage[i].src == SRC_SCR) scr_pend_c = 1'b1;
    end
  end

endmodule

// File: rtl/align_dwsn_sched.sv
// Two-client round-robin arbiter with idle-cycle parity scrub and error log
// in front of a single-port align_dwsn memory.
module align_dwsn_sched
  import align_dwsn_sched_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned BITADDR    = 10,
  parameter int unsigned NUMADDR    = 1024,
  parameter int unsigned BITPADR    = 10,
  parameter int unsigned SRAM_DELAY = 2,
  parameter int unsigned FLOPMEM    = 0,
  parameter int unsigned BITECNT    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               c0_read,
  input  logic               c0_write,
  input  logic [BITADDR-1:0] c0_addr,
  input  logic [WIDTH-1:0]   c0_din,
  output logic               c0_gnt,
  output logic               c0_vld,
  output logic [WIDTH-1:0]   c0_dout,
  output logic               c0_serr,
  input  logic               c1_read,
  input  logic               c1_write,
  input  logic [BITADDR-1:0] c1_addr,
  input  logic [WIDTH-1:0]   c1_din,
  output logic               c1_gnt,
  output logic               c1_vld,
  output logic [WIDTH-1:0]   c1_dout,
  output logic               c1_serr,
  output logic               read,
  output logic               write,
  output logic [BITADDR-1:0] addr,
  output logic [WIDTH-1:0]   din,
  input  logic [WIDTH-1:0]   dout,
  input  logic               serr,
  input  logic [BITPADR-1:0] padr,
  input  logic               scrub_en,
  output logic               scrub_done,
  input  logic               err_clr,
  output logic               err_vld,
  output logic [BITPADR-1:0] err_padr,
  output logic [SRC_W-1:0]   err_src,
  output logic [BITECNT-1:0] err_cnt
);

  localparam int unsigned        RDLY      = calc_rdly(SRAM_DELAY, FLOPMEM);
  localparam logic [BITADDR-1:0] LAST_ADDR = BITADDR'(NUMADDR - 1);

  logic               req0, req1, gnt_scr, rr;
  logic [SRC_W-1:0]   load_src, tail_src;
  logic               tail_vld, scr_pend_c, ret_err;
  scrub_state_e       state, state_nxt;
  logic [BITADDR-1:0] ptr, ptr_nxt;

  // rr=0 prefers c0; scrub only takes cycles no client wants.
  always_comb begin
    req0    = c0_read | c0_write;
    req1    = c1_read | c1_write;
    c0_gnt  = req0 && (!req1 || !rr);
    c1_gnt  = req1 && (!req0 || rr);
    gnt_scr = (state == S_RUN) && scrub_en && !req0 && !req1;
  end

  always_comb begin
    read     = 1'b0;
    write    = 1'b0;
    addr     = '0;
    din      = '0;
    load_src = SRC_SCR;
    if (c0_gnt) begin
      read     = c0_read & ~c0_write;
      write    = c0_write;
      addr     = c0_addr;
      din      = c0_din;
      load_src = SRC_C0;
    end else if (c1_gnt) begin
      read     = c1_read & ~c1_write;
      write    = c1_write;
      addr     = c1_addr;
      din      = c1_din;
      load_src = SRC_C1;
    end else if (gnt_scr) begin
      read = 1'b1;
      addr = ptr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rr <= 1'b0;
    else if (c0_gnt) rr <= 1'b1;
    else if (c1_gnt) rr <= 1'b0;
  end

  align_dwsn_retpipe #(.RDLY(RDLY)) u_retpipe (
    .clk        (clk),
    .rst        (rst),
    .load       (read),
    .load_src   (load_src),
    .tail_vld   (tail_vld),
    .tail_src   (tail_src),
    .scr_pend_c (scr_pend_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Scrub walker; pointer is held across pauses so a pass resumes in place.
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    scrub_done = 1'b0;
    case (state)
      S_IDLE: if (scrub_en) state_nxt = S_RUN;
      S_RUN: begin
        if (!scrub_en) begin
          state_nxt = S_IDLE;
        end else if (gnt_scr) begin
          if (ptr == LAST_ADDR) begin
            ptr_nxt   = '0;
            state_nxt = S_DRAIN;
          end else begin
            ptr_nxt = ptr + BITADDR'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!scr_pend_c) begin
          scrub_done = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign c0_vld  = tail_vld && (tail_src == SRC_C0);
  assign c1_vld  = tail_vld && (tail_src == SRC_C1);
  assign c0_dout = dout;
  assign c1_dout = dout;
  assign c0_serr = c0_vld && serr;
  assign c1_serr = c1_vld && serr;
  assign ret_err = tail_vld && serr;

  // First-error capture plus saturating count; a same-cycle error beats clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_vld  <= 1'b0;
      err_padr <= '0;
      err_src  <= '0;
      err_cnt  <= '0;
    end else if (err_clr) begin
      err_vld  <= ret_err;
      err_padr <= ret_err ? padr : '0;
      err_src  <= ret_err ? tail_src : '0;
      err_cnt  <= ret_err ? BITECNT'(1) : '0;
    end else if (ret_err) begin
      if (err_cnt != '1) err_cnt <= err_cnt + BITECNT'(1);
      if (!err_vld) begin
        err_vld  <= 1'b1;
        err_padr <= padr;
        err_src  <= tail_src;
      end
    end
  end

endmodule

// File: tb/tb_align_dwsn_sched.sv
// Directed bench for align_dwsn_sched with a latency-2 memory model and a
// scoreboard that pairs client read returns with queued expectations.
module tb_align_dwsn_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        c0_read, c0_write, c1_read, c1_write;
  logic [9:0]  c0_addr, c1_addr;
  logic [31:0] c0_din, c1_din;
  logic        c0_gnt, c0_vld, c0_serr, c1_gnt, c1_vld, c1_serr;
  logic [31:0] c0_dout, c1_dout;
  logic        read, write;
  logic [9:0]  addr;
  logic [31:0] din, dout;
  logic        serr;
  logic [9:0]  padr;
  logic        scrub_en, scrub_done, err_clr, err_vld;
  logic [9:0]  err_padr;
  logic [1:0]  err_src;
  logic [7:0]  err_cnt;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [32:0] exp0 [$];
  logic [32:0] exp1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  align_dwsn_sched #(
    .WIDTH(32), .BITADDR(10), .NUMADDR(8), .BITPADR(10),
    .SRAM_DELAY(2), .FLOPMEM(0), .BITECNT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .c0_read(c0_read), .c0_write(c0_write), .c0_addr(c0_addr), .c0_din(c0_din),
    .c0_gnt(c0_gnt), .c0_vld(c0_vld), .c0_dout(c0_dout), .c0_serr(c0_serr),
    .c1_read(c1_read), .c1_write(c1_write), .c1_addr(c1_addr), .c1_din(c1_din),
    .c1_gnt(c1_gnt), .c1_vld(c1_vld), .c1_dout(c1_dout), .c1_serr(c1_serr),
    .read(read), .write(write), .addr(addr), .din(din),
    .dout(dout), .serr(serr), .padr(padr),
    .scrub_en(scrub_en), .scrub_done(scrub_done),
    .err_clr(err_clr), .err_vld(err_vld), .err_padr(err_padr),
    .err_src(err_src), .err_cnt(err_cnt)
  );

  // Memory model: fixed contents, one overridable written word, latency 2.
  logic        serr_map [1024];
  logic        mp_rd   [2];
  logic [9:0]  mp_addr [2];
  logic        wr_seen = 1'b0;
  logic [9:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;

  function automatic logic [31:0] base(input logic [9:0] a);
    return 32'h1000_0000 + 32'(a) * 32'h0101_0011;
  endfunction

  always @(posedge clk) begin
    mp_rd[0]   <= read;
    mp_addr[0] <= addr;
    mp_rd[1]   <= mp_rd[0];
    mp_addr[1] <= mp_addr[0];
    if (write) begin
      wr_seen <= 1'b1;
      wr_addr <= addr;
      wr_data <= din;
    end
  end

  assign dout = (wr_seen && mp_addr[1] == wr_addr) ? wr_data : base(mp_addr[1]);
  assign serr = mp_rd[1] & serr_map[mp_addr[1]];
  assign padr = mp_addr[1] ^ 10'h028;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Scoreboard monitor: every client return must match the oldest expectation.
  always @(negedge clk) begin
    logic [32:0] e;
    if (c0_vld) begin
      if (exp0.size() == 0) chk("c0_vld_unexpected", c0_vld, 0);
      else begin
        e = exp0.pop_front();
        chk("c0_dout", c0_dout, e[31:0]);
        chk("c0_serr", c0_serr, e[32]);
      end
    end
    if (c1_vld) begin
      if (exp1.size() == 0) chk("c1_vld_unexpected", c1_vld, 0);
      else begin
        e = exp1.pop_front();
        chk("c1_dout", c1_dout, e[31:0]);
        chk("c1_serr", c1_serr, e[32]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    c0_read = 0; c0_write = 0; c0_addr = '0; c0_din = '0;
    c1_read = 0; c1_write = 0; c1_addr = '0; c1_din = '0;
    scrub_en = 0; err_clr = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_scrub(input int limit, output bit found, output logic [9:0] a);
    found = 0;
    a = '0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (read && !c0_gnt && !c1_gnt) begin
        found = 1;
        a = addr;
        return;
      end
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_read"}, read, 0);
    chk({tag, "_write"}, write, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_c0_gnt"}, c0_gnt, 0);
    chk({tag, "_vld"}, {c0_vld, c1_vld}, 0);
    chk({tag, "_scrub_done"}, scrub_done, 0);
    chk({tag, "_err"}, {err_vld, err_padr, err_src, err_cnt}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    logic [9:0] a;
    int n, first, c7;
    bit done_seen;
    int cnt;

    for (int i = 0; i < 1024; i++) serr_map[i] = 1'b0;
    rst = 1'b1;
    clear_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset_din", din, 0);
    step();
    rst = 1'b0;

    // Single c0 read of addr 5: grant now, data two cycles later.
    c0_read = 1; c0_addr = 10'd5;
    exp0.push_back({1'b0, base(10'd5)});
    @(negedge clk);
    chk("t0_c0_gnt", c0_gnt, 1);
    chk("t0_c1_gnt", c1_gnt, 0);
    chk("t0_mem", {read, write, addr}, {1'b1, 1'b0, 10'd5});
    step();
    c0_read = 0;
    @(negedge clk);
    chk("t1_c0_vld", c0_vld, 0);
    @(negedge clk);
    chk("t2_c0_vld", c0_vld, 1);
    chk("t2_c1_vld", c1_vld, 0);

    // read&write together acts as a write; read back afterwards.
    step();
    c1_read = 1; c1_write = 1; c1_addr = 10'd9; c1_din = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("wr_gnt", c1_gnt, 1);
    chk("wr_mem", {read, write, addr}, {1'b0, 1'b1, 10'd9});
    chk("wr_din", din, 32'hDEAD_BEEF);
    step();
    c1_write = 0;
    exp1.push_back({1'b0, 32'hDEAD_BEEF});
    @(negedge clk);
    chk("rd9_mem", {c1_gnt, read, addr}, {1'b1, 1'b1, 10'd9});
    step();
    c1_read = 0;
    repeat (3) @(negedge clk);

    // Both clients saturating: strict alternation starting with c0.
    do_reset();
    c0_read = 1; c0_addr = 10'd1;
    c1_read = 1; c1_addr = 10'd2;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) exp0.push_back({1'b0, base(10'd1)});
      else            exp1.push_back({1'b0, base(10'd2)});
      @(negedge clk);
      chk("rr_gnt", {c0_gnt, c1_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
      chk("rr_addr", {read, addr}, {1'b1, (k % 2 == 0) ? 10'd1 : 10'd2});
      step();
    end
    c0_read = 0; c1_read = 0;
    repeat (4) @(negedge clk);

    // Full scrub pass over 8 addresses, then restart at 0.
    step();
    scrub_en = 1;
    n = 0; first = 0; c7 = -100; done_seen = 0;
    for (int i = 0; i < 60 && n < 10; i++) begin
      @(negedge clk);
      if (scrub_done) begin
        chk("scrub_done_delay", cyc - c7, 2);
        done_seen = 1;
      end
      if (read && !c0_gnt && !c1_gnt) begin
        chk("scrub_addr", addr, n % 8);
        if (n == 0) first = cyc;
        if (n < 8) chk("scrub_back_to_back", cyc - first, n);
        if (n == 7) c7 = cyc;
        n++;
      end
    end
    chk("scrub_done_seen", done_seen, 1);
    chk("scrub_read_count", n, 10);
    step();
    scrub_en = 0;
    repeat (6) @(negedge clk);

    // Pause after addr 3, resume at addr 4.
    do_reset();
    scrub_en = 1;
    for (int j = 0; j < 4; j++) begin
      wait_scrub(10, found, a);
      chk("pause_seq", {found, a}, {1'b1, 10'(j)});
    end
    step();
    scrub_en = 0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (read) cnt++;
    end
    chk("pause_no_reads", cnt, 0);
    step();
    scrub_en = 1;
    wait_scrub(10, found, a);
    chk("resume_addr", {found, a}, {1'b1, 10'd4});
    step();
    scrub_en = 0;
    repeat (4) @(negedge clk);

    // Error log: scrub error at addr 2, then a c1 error, then clear races.
    do_reset();
    serr_map[2] = 1'b1;
    scrub_en = 1;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (err_vld) found = 1;
    end
    chk("scrub_err_seen", found, 1);
    step();
    scrub_en = 0;
    chk("err1", {err_vld, err_padr, err_src, err_cnt}, {1'b1, 10'h02A, 2'd2, 8'd1});
    serr_map[6] = 1'b1;
    repeat (3) @(negedge clk);
    step();
    exp1.push_back({1'b1, base(10'd6)});
    c1_read = 1; c1_addr = 10'd6;
    step();
    c1_read = 0;
    repeat (3) @(negedge clk);
    chk("err2", {err_vld, err_padr, err_src, err_cnt}, {1'b1, 10'h02A, 2'd2, 8'd2});
    step();
    exp0.push_back({1'b1, base(10'd6)});
    c0_read = 1; c0_addr = 10'd6;
    step();
    c0_read = 0;
    step();
    err_clr = 1;
    step();
    err_clr = 0;
    @(negedge clk);
    chk("clr_and_err", {err_vld, err_padr, err_src, err_cnt}, {1'b1, 10'h02E, 2'd0, 8'd1});
    step();
    err_clr = 1;
    step();
    err_clr = 0;
    @(negedge clk);
    chk("clr_only", {err_vld, err_padr, err_src, err_cnt}, 0);
    serr_map[2] = 1'b0;
    serr_map[6] = 1'b0;

    // Reset with reads in flight: nothing returns, scrub restarts at 0.
    step();
    c0_read = 1; c0_addr = 10'd1;
    step();
    c0_addr = 10'd3;
    @(negedge clk);
    rst = 1'b1;
    c0_read = 0;
    @(negedge clk);
    chk_idle_outputs("midrst");
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_vld", {c0_vld, c1_vld}, 0);
    end
    step();
    scrub_en = 1;
    wait_scrub(10, found, a);
    chk("post_rst_scrub", {found, a}, {1'b1, 10'd0});
    step();
    scrub_en = 0;

    repeat (4) @(negedge clk);
    chk("exp0_drained", exp0.size(), 0);
    chk("exp1_drained", exp1.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
